// File: rtl/quaddectest_cpu_oci_dct_packer_pkg.sv
// Shared constants and types for the DCT trace frame packer.
package quaddectest_cpu_oci_dct_pkg;

    localparam int REC_W  = 2;             // bits per DCT record
    localparam int DEPTH  = 15;            // records per full frame
    localparam int BUF_W  = REC_W * DEPTH; // 30-bit packed frame
    localparam int CNT_W  = 4;             // record count width
    localparam int STAT_W = 16;            // saturating statistics counter width

    typedef struct packed {
        logic [BUF_W-1:0] buffer;
        logic [CNT_W-1:0] count;
    } dct_frame_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/quaddectest_cpu_oci_dct_packer_if.sv
// Record-in / frame-out handshake bundle of the DCT packer.
// master: the packer itself; slave: trace capture plus frame consumer side.
interface quaddectest_cpu_oci_dct_packer_if;
    import quaddectest_cpu_oci_dct_pkg::*;

    logic             rec_valid;
    logic [REC_W-1:0] rec_data;
    logic             rec_ready;
    logic             flush;
    logic             frm_valid;
    logic             frm_ready;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;

    modport master (
        input  rec_valid, rec_data, flush, frm_ready,
        output rec_ready, frm_valid, dct_buffer, dct_count
    );

    modport slave (
        output rec_valid, rec_data, flush, frm_ready,
        input  rec_ready, frm_valid, dct_buffer, dct_count
    );

endinterface

// File: rtl/quaddectest_cpu_oci_dct_packer_slot.sv
// Output holding register: loaded by emit_i, drained by the consumer's ready.
module quaddectest_cpu_oci_dct_slot
    import quaddectest_cpu_oci_dct_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       emit_i,
    input  dct_frame_t frame_i,
    input  logic       frm_ready_i,
    output logic       frm_valid_o,
    output dct_frame_t frame_o,
    output logic       slot_free_o
);

    logic       valid_q, valid_d;
    dct_frame_t frame_q, frame_d;

    // A new frame wins over draining; drained data is kept but marked invalid.
    always_comb begin
        valid_d = valid_q;
        frame_d = frame_q;
        if (emit_i) begin
            valid_d = 1'b1;
            frame_d = frame_i;
        end else if (frm_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            frame_q <= '0;
        end else begin
            valid_q <= valid_d;
            frame_q <= frame_d;
        end
    end

    assign frm_valid_o = valid_q;
    assign frame_o     = frame_q;
    assign slot_free_o = !valid_q || frm_ready_i;

endmodule

// File: rtl/quaddectest_cpu_oci_dct_packer.sv
// DCT record packer: shifts 2-bit records into a 30-bit accumulator and
// hands full or flushed frames to a single-entry output slot.
// Optional feature macro: QUADDEC_DCT_STATS_EN adds frm_total / stall_cycles.
module quaddectest_cpu_oci_dct_packer
    import quaddectest_cpu_oci_dct_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    quaddectest_cpu_oci_dct_packer_if.master dct
`ifdef QUADDEC_DCT_STATS_EN
    ,
    output logic [STAT_W-1:0]             frm_total,
    output logic [STAT_W-1:0]             stall_cycles
`endif
);

    logic [BUF_W-1:0] acc_buf_q, acc_buf_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             flush_pend_q, flush_pend_d;

    logic             rec_ready;
    logic             accept;
    logic [CNT_W-1:0] post_cnt;
    logic [BUF_W-1:0] post_buf;
    logic             emit_req;
    logic             emit;
    logic             slot_free;
    dct_frame_t       slot_frame;

    // Ready comes from registered state only, so FULL stalls until the slot moves.
    assign rec_ready = (acc_cnt_q != CNT_W'(DEPTH));
    assign accept    = dct.rec_valid && rec_ready;
    assign post_cnt  = acc_cnt_q + CNT_W'(accept);
    assign post_buf  = accept ? {acc_buf_q[BUF_W-REC_W-1:0], dct.rec_data} : acc_buf_q;
    assign emit_req  = (post_cnt == CNT_W'(DEPTH)) ||
                       ((post_cnt != '0) && (dct.flush || flush_pend_q));
    assign emit      = emit_req && slot_free;

    // Accumulator and pending-flush next state; an empty flush is dropped.
    always_comb begin
        acc_buf_d    = post_buf;
        acc_cnt_d    = post_cnt;
        flush_pend_d = flush_pend_q;
        if (emit) begin
            acc_buf_d    = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
        end else if (dct.flush) begin
            flush_pend_d = (post_cnt != '0);
        end
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    quaddectest_cpu_oci_dct_slot u_slot (
        .clk         (clk),
        .reset       (reset),
        .emit_i      (emit),
        .frame_i     ('{buffer: post_buf, count: post_cnt}),
        .frm_ready_i (dct.frm_ready),
        .frm_valid_o (dct.frm_valid),
        .frame_o     (slot_frame),
        .slot_free_o (slot_free)
    );

    assign dct.rec_ready  = rec_ready;
    assign dct.dct_buffer = slot_frame.buffer;
    assign dct.dct_count  = slot_frame.count;

`ifdef QUADDEC_DCT_STATS_EN
    logic [STAT_W-1:0] frm_total_q;
    logic [STAT_W-1:0] stall_cycles_q;

    // Saturating counts of completed frame handshakes and stalled records.
    always_ff @(posedge clk) begin
        if (reset) begin
            frm_total_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (dct.frm_valid && dct.frm_ready) frm_total_q <= sat_inc(frm_total_q);
            if (dct.rec_valid && !rec_ready)    stall_cycles_q <= sat_inc(stall_cycles_q);
        end
    end

    assign frm_total    = frm_total_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_quaddectest_cpu_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed scenarios plus random traffic,
// all checked against a queue-based model of the record/frame rules.
module tb_quaddectest_cpu_oci_dct_packer;
    import quaddectest_cpu_oci_dct_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    quaddectest_cpu_oci_dct_packer_if u_if ();

`ifdef QUADDEC_DCT_STATS_EN
    logic [15:0] frm_total;
    logic [15:0] stall_cycles;
`endif

    quaddectest_cpu_oci_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .dct          (u_if)
`ifdef QUADDEC_DCT_STATS_EN
        ,
        .frm_total    (frm_total),
        .stall_cycles (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: records waiting in arrival order, pending flush, output slot contents.
    logic [1:0]  mq[$];
    bit          m_pend;
    bit          m_fv;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    logic [33:0] taken_q[$];
    int          m_total;
    int          m_stall;

    function automatic logic [29:0] pack_queue();
        logic [29:0] b = '0;
        foreach (mq[i]) b = (b << 2) | 30'(mq[i]);
        return b;
    endfunction

    // Advance the model over one clock using the current inputs, clock the DUT, compare.
    task automatic cycle();
        bit ready_m, free_m, req_m;
        int n;
        if (reset) begin
            mq.delete();
            m_pend = 0; m_fv = 0; m_buf = '0; m_cnt = '0;
            m_total = 0; m_stall = 0;
        end else begin
            ready_m = (mq.size() != DEPTH);
            free_m  = !m_fv || u_if.frm_ready;
            if (u_if.rec_valid && !ready_m && m_stall < 65535) m_stall++;
            if (m_fv && u_if.frm_ready) begin
                taken_q.push_back({m_buf, m_cnt});
                if (m_total < 65535) m_total++;
            end
            if (u_if.rec_valid && ready_m) mq.push_back(u_if.rec_data);
            n = mq.size();
            req_m = (n == DEPTH) || (n > 0 && (u_if.flush || m_pend));
            if (req_m && free_m) begin
                m_buf = pack_queue(); m_cnt = 4'(n); m_fv = 1;
                mq.delete(); m_pend = 0;
            end else begin
                if (free_m) m_fv = 0;
                if (u_if.flush) m_pend = (n > 0);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (u_if.rec_ready !== (mq.size() != DEPTH)) begin
            errors++;
            $display("FAIL cycle_rec_ready: got %0b expected %0b", u_if.rec_ready, mq.size() != DEPTH);
        end
        checks++;
        if (u_if.frm_valid !== m_fv) begin
            errors++;
            $display("FAIL cycle_frm_valid: got %0b expected %0b", u_if.frm_valid, m_fv);
        end
        checks++;
        if (u_if.dct_buffer !== m_buf || u_if.dct_count !== m_cnt) begin
            errors++;
            $display("FAIL cycle_frame: got %h/%0d expected %h/%0d",
                     u_if.dct_buffer, u_if.dct_count, m_buf, m_cnt);
        end
`ifdef QUADDEC_DCT_STATS_EN
        checks++;
        if (frm_total !== 16'(m_total) || stall_cycles !== 16'(m_stall)) begin
            errors++;
            $display("FAIL cycle_stats: got %0d/%0d expected %0d/%0d",
                     frm_total, stall_cycles, m_total, m_stall);
        end
`endif
    endtask

    task automatic send(input logic [1:0] d, input bit fl);
        u_if.rec_valid = 1'b1; u_if.rec_data = d; u_if.flush = fl;
        cycle();
        u_if.rec_valid = 1'b0; u_if.flush = 1'b0;
    endtask

    task automatic flush_only();
        u_if.flush = 1'b1;
        cycle();
        u_if.flush = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic check_frame(input string name, input logic [29:0] b, input logic [3:0] c);
        checks++;
        if (u_if.frm_valid !== 1'b1 || u_if.dct_buffer !== b || u_if.dct_count !== c) begin
            errors++;
            $display("FAIL %s: got v=%0b %h/%0d expected v=1 %h/%0d",
                     name, u_if.frm_valid, u_if.dct_buffer, u_if.dct_count, b, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        checks++;
        if (u_if.frm_valid !== 1'b0 || u_if.rec_ready !== 1'b1 ||
            u_if.dct_buffer !== 30'h0 || u_if.dct_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: got v=%0b r=%0b %h/%0d expected v=0 r=1 0/0",
                     u_if.frm_valid, u_if.rec_ready, u_if.dct_buffer, u_if.dct_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        u_if.frm_ready = 1'b1;
        taken_q.delete();
        for (int i = 0; i < 15; i++) send(2'b01, 1'b0);
        check_frame("full_frame", 30'h15555555, 4'd15);
        idle(1);
        checks++;
        if (taken_q.size() != 1) begin
            errors++;
            $display("FAIL full_frame_taken: got %0d expected 1", taken_q.size());
        end
        $display("test_full_frame done");
    endtask

    task automatic test_flush();
        send(2'b11, 1'b0); send(2'b10, 1'b0); send(2'b01, 1'b0);
        flush_only();
        check_frame("flush_frame", 30'h39, 4'd3);
        idle(1);
        $display("test_flush done");
    endtask

    task automatic test_empty_flush();
        flush_only();
        checks++;
        if (u_if.frm_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_flush_valid: got %0b expected 0", u_if.frm_valid);
        end
        send(2'b00, 1'b0);
        checks++;
        if (u_if.frm_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_flush_no_pend: got %0b expected 0", u_if.frm_valid);
        end
        flush_only();
        idle(1);
        $display("test_empty_flush done");
    endtask

    task automatic test_back_to_back();
        u_if.frm_ready = 1'b0;
        taken_q.delete();
        for (int i = 0; i < 30; i++) send(2'b10, 1'b0);
        checks++;
        if (u_if.rec_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got rec_ready=%0b expected 0", u_if.rec_ready);
        end
        check_frame("b2b_held", 30'h2AAAAAAA, 4'd15);
        u_if.frm_ready = 1'b1;
        idle(2);
        checks++;
        if (taken_q.size() != 2 || taken_q[0] !== {30'h2AAAAAAA, 4'd15} ||
            taken_q[1] !== {30'h2AAAAAAA, 4'd15} || u_if.rec_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frames: got n=%0d r=%0b expected n=2 r=1 both 2aaaaaaa/15",
                     taken_q.size(), u_if.rec_ready);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_flush_busy();
        u_if.frm_ready = 1'b0;
        send(2'b01, 1'b1);
        check_frame("rec_with_flush", 30'h1, 4'd1);
        for (int i = 0; i < 5; i++) send(2'b11, 1'b0);
        flush_only();
        idle(2);
        check_frame("busy_hold", 30'h1, 4'd1);
        u_if.frm_ready = 1'b1;
        idle(1);
        check_frame("pending_flush", 30'h3FF, 4'd5);
        idle(1);
        $display("test_flush_busy done");
    endtask

    task automatic test_reset_mid();
        u_if.frm_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(2'b10, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (u_if.frm_valid !== 1'b0 || u_if.rec_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b r=%0b expected v=0 r=1", u_if.frm_valid, u_if.rec_ready);
        end
        for (int i = 0; i < 15; i++) send(2'b01, 1'b0);
        check_frame("reset_mid_frame", 30'h15555555, 4'd15);
        idle(1);
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            u_if.rec_valid = ($urandom_range(0, 3) != 0);
            u_if.rec_data  = 2'($urandom_range(0, 3));
            u_if.flush     = ($urandom_range(0, 15) == 0);
            u_if.frm_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        u_if.rec_valid = 1'b0; u_if.flush = 1'b0; u_if.frm_ready = 1'b1;
        idle(2);
        $display("test_random done");
    endtask

    initial begin
        reset = 1'b1;
        u_if.rec_valid = 1'b0;
        u_if.rec_data  = 2'b00;
        u_if.flush     = 1'b0;
        u_if.frm_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_flush();
        test_empty_flush();
        test_back_to_back();
        test_flush_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
